banco_temporizadores: RTL



---
 rtl/temporizadores_pkg.sv | 31 +++
 rtl/contador_fase.sv | 34 +++
 rtl/banco_temporizadores.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/temporizadores_pkg.sv
// rtl/temporizadores_pkg.sv - phase enum, default time constants and counter sizing for the timer bank
package temporizadores_pkg;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    PRESS  = 2'd1,
    AQUEC  = 2'd2,
    BEBIDA = 2'd3
  } fase_e;

  localparam int TICKS_PER_SEC_DEF = 1000;
  localparam int T_PRESS_DEF       = 2;
  localparam int T_AQUEC_DEF       = 2;
  localparam int T_BEBIDA_DEF      = 5;
  localparam int T_VENDA_DEF       = 15;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Width that holds max_ticks-1, the largest value ever loaded.
  function automatic int cnt_width(input int max_ticks);
    return (max_ticks > 1) ? $clog2(max_ticks) : 1;
  endfunction

endpackage

// File: rtl/contador_fase.sv
// rtl/contador_fase.sv - loadable down-counter with enable and zero flag, saturating at 0
module contador_fase #(
  parameter int W = 4
) (
  input  logic         clk3,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk3) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/banco_temporizadores.sv
// rtl/banco_temporizadores.sv - phase chain and sale timeout for the vending FSM; TEMP_PAUSA_EN adds the pausa input
module banco_temporizadores
  import temporizadores_pkg::*;
#(
  parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF,
  parameter int T_PRESS       = T_PRESS_DEF,
  parameter int T_AQUEC       = T_AQUEC_DEF,
  parameter int T_BEBIDA      = T_BEBIDA_DEF,
  parameter int T_VENDA       = T_VENDA_DEF
) (
  input  logic clk3,
  input  logic reset,
`ifdef TEMP_PAUSA_EN
  input  logic pausa,
`endif
  input  logic reset_Temp_2,
  input  logic reset_Temp_15,
  input  logic Cancel,
  output logic Temp_2,
  output logic Temp_2_1,
  output logic Temp_5,
  output logic Temp_15,
  output logic prep_done
);

  localparam int CW = cnt_width(max4(T_PRESS, T_AQUEC, T_BEBIDA, T_VENDA) * TICKS_PER_SEC);

  localparam logic [CW-1:0] LD_PRESS  = CW'(T_PRESS  * TICKS_PER_SEC - 1);
  localparam logic [CW-1:0] LD_AQUEC  = CW'(T_AQUEC  * TICKS_PER_SEC - 1);
  localparam logic [CW-1:0] LD_BEBIDA = CW'(T_BEBIDA * TICKS_PER_SEC - 1);
  localparam logic [CW-1:0] LD_VENDA  = CW'(T_VENDA  * TICKS_PER_SEC - 1);

  logic run;
`ifdef TEMP_PAUSA_EN
  assign run = ~pausa;
`else
  assign run = 1'b1;
`endif

  logic    rt2_q, rt15_q;
  logic    start, arm;
  fase_e   fase_q, fase_d;
  logic    armed_q, armed_d;
  logic    prep_done_q, prep_done_d;
  logic    ld_fase, ld_venda;
  logic [CW-1:0] ldv_fase;
  logic    zero_fase, zero_venda;
  logic    expira;

  assign start = reset_Temp_2 & ~rt2_q;
  assign arm   = reset_Temp_15 & ~rt15_q;

  always_comb begin
    fase_d      = fase_q;
    ld_fase     = 1'b0;
    ldv_fase    = LD_PRESS;
    prep_done_d = 1'b0;
    if (Cancel) begin
      fase_d = OCIOSO;
    end else begin
      unique case (fase_q)
        OCIOSO: begin
          if (start) begin
            fase_d   = PRESS;
            ld_fase  = 1'b1;
            ldv_fase = LD_PRESS;
          end
        end
        PRESS: begin
          if (run && zero_fase) begin
            fase_d   = AQUEC;
            ld_fase  = 1'b1;
            ldv_fase = LD_AQUEC;
          end
        end
        AQUEC: begin
          if (run && zero_fase) begin
            fase_d   = BEBIDA;
            ld_fase  = 1'b1;
            ldv_fase = LD_BEBIDA;
          end
        end
        BEBIDA: begin
          if (run && zero_fase) begin
            fase_d      = OCIOSO;
            prep_done_d = 1'b1;
          end
        end
        default: fase_d = OCIOSO;
      endcase
    end
  end

  // A fresh arm restarts the period and swallows a coincident expiry.
  assign expira = armed_q & zero_venda & run & ~Cancel & ~arm;

  always_comb begin
    armed_d  = armed_q;
    ld_venda = 1'b0;
    if (Cancel) begin
      armed_d = 1'b0;
    end else if (arm) begin
      armed_d  = 1'b1;
      ld_venda = 1'b1;
    end else if (expira) begin
      armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk3) begin
    if (reset) begin
      rt2_q       <= 1'b0;
      rt15_q      <= 1'b0;
      fase_q      <= OCIOSO;
      armed_q     <= 1'b0;
      prep_done_q <= 1'b0;
    end else begin
      rt2_q       <= reset_Temp_2;
      rt15_q      <= reset_Temp_15;
      fase_q      <= fase_d;
      armed_q     <= armed_d;
      prep_done_q <= prep_done_d;
    end
  end

  contador_fase #(.W(CW)) u_cnt_fase (
    .clk3     (clk3),
    .reset    (reset),
    .load     (ld_fase),
    .load_val (ldv_fase),
    .en       (run && (fase_q != OCIOSO)),
    .zero     (zero_fase)
  );

  contador_fase #(.W(CW)) u_cnt_venda (
    .clk3     (clk3),
    .reset    (reset),
    .load     (ld_venda),
    .load_val (LD_VENDA),
    .en       (run && armed_q),
    .zero     (zero_venda)
  );

  assign Temp_2    = (fase_q == PRESS);
  assign Temp_2_1  = (fase_q == AQUEC);
  assign Temp_5    = (fase_q == BEBIDA);
  assign Temp_15   = expira;
  assign prep_done = prep_done_q;

endmodule
